// File: rtl/leitor_banco_registradores_if.sv
// Bus between the register-dump reader and its surroundings: start request,
// register-file read port, and the valid/ready output stream.
// The master modport is the reader; the slave modport is the register file
// plus the consumer.
interface leitor_banco_registradores_if #(
    parameter int LARGURA_DADOS = 32,
    parameter int BITS_INDICE   = 5
) ();
    logic                     iniciar;
    logic [BITS_INDICE-1:0]   reg_inicio;
    logic [BITS_INDICE-1:0]   reg_fim;
    logic [BITS_INDICE-1:0]   reg_leitura;
    logic [LARGURA_DADOS-1:0] dados_leitura;
    logic                     saida_valid;
    logic                     saida_ready;
    logic [LARGURA_DADOS-1:0] saida_dados;
    logic [BITS_INDICE-1:0]   saida_indice;
    logic                     ocupado;
    logic                     concluido;

    modport master (
        input  iniciar,
        input  reg_inicio,
        input  reg_fim,
        input  dados_leitura,
        input  saida_ready,
        output reg_leitura,
        output saida_valid,
        output saida_dados,
        output saida_indice,
        output ocupado,
        output concluido
    );

    modport slave (
        output iniciar,
        output reg_inicio,
        output reg_fim,
        output dados_leitura,
        output saida_ready,
        input  reg_leitura,
        input  saida_valid,
        input  saida_dados,
        input  saida_indice,
        input  ocupado,
        input  concluido
    );
endinterface

// File: rtl/leitor_banco_registradores.sv
// Register-file dump reader: walks indices inicio..fim (inclusive, wrapping
// modulo 2^BITS_INDICE), reads each register through a combinational read
// port and offers it on a valid/ready stream. Concluido pulses once at the end.
// Optional feature: define ZERO_R0_EN to force register 0 to read as zero.
module leitor_banco_registradores #(
    parameter int LARGURA_DADOS = 32,
    parameter int BITS_INDICE   = 5
) (
    input logic i_clk,
    input logic i_rst,
    leitor_banco_registradores_if.master bus
);

    typedef enum logic [1:0] {
        StOcioso,
        StLer,
        StEnviar,
        StFim
    } t_estado;

    t_estado                  r_estado;
    t_estado                  w_estado_prox;
    logic [BITS_INDICE-1:0]   r_indice;
    logic [BITS_INDICE-1:0]   w_indice_prox;
    logic [BITS_INDICE-1:0]   r_fim;
    logic [BITS_INDICE-1:0]   w_fim_prox;
    logic                     r_valid;
    logic                     w_valid_prox;
    logic [LARGURA_DADOS-1:0] r_dados;
    logic [LARGURA_DADOS-1:0] w_dados_prox;
    logic [BITS_INDICE-1:0]   r_saida_indice;
    logic [BITS_INDICE-1:0]   w_saida_indice_prox;
    logic [LARGURA_DADOS-1:0] w_dados_lidos;

`ifdef ZERO_R0_EN
    // R0 is hardwired to zero regardless of what the register file returns.
    assign w_dados_lidos = (r_indice == '0) ? '0 : bus.dados_leitura;
`else
    assign w_dados_lidos = bus.dados_leitura;
`endif

    // State and datapath registers; synchronous reset returns everything to idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_estado       <= StOcioso;
            r_indice       <= '0;
            r_fim          <= '0;
            r_valid        <= 1'b0;
            r_dados        <= '0;
            r_saida_indice <= '0;
        end else begin
            r_estado       <= w_estado_prox;
            r_indice       <= w_indice_prox;
            r_fim          <= w_fim_prox;
            r_valid        <= w_valid_prox;
            r_dados        <= w_dados_prox;
            r_saida_indice <= w_saida_indice_prox;
        end
    end

    // Next-state logic: latch the range on start, read one word, wait for the
    // handshake, then either step to the next index or finish.
    always_comb begin
        w_estado_prox       = r_estado;
        w_indice_prox       = r_indice;
        w_fim_prox          = r_fim;
        w_valid_prox        = r_valid;
        w_dados_prox        = r_dados;
        w_saida_indice_prox = r_saida_indice;

        unique case (r_estado)
            StOcioso: begin
                if (bus.iniciar) begin
                    w_indice_prox = bus.reg_inicio;
                    w_fim_prox    = bus.reg_fim;
                    w_estado_prox = StLer;
                end
            end
            StLer: begin
                w_dados_prox        = w_dados_lidos;
                w_saida_indice_prox = r_indice;
                w_valid_prox        = 1'b1;
                w_estado_prox       = StEnviar;
            end
            StEnviar: begin
                if (r_valid && bus.saida_ready) begin
                    w_valid_prox = 1'b0;
                    if (r_indice == r_fim) begin
                        w_estado_prox = StFim;
                    end else begin
                        // Natural overflow gives the wrap from the last register to 0.
                        w_indice_prox = r_indice + BITS_INDICE'(1);
                        w_estado_prox = StLer;
                    end
                end
            end
            StFim: begin
                w_estado_prox = StOcioso;
            end
            default: begin
                w_estado_prox = StOcioso;
            end
        endcase
    end

    assign bus.reg_leitura  = r_indice;
    assign bus.saida_valid  = r_valid;
    assign bus.saida_dados  = r_dados;
    assign bus.saida_indice = r_saida_indice;
    assign bus.ocupado      = (r_estado != StOcioso);
    assign bus.concluido    = (r_estado == StFim);

endmodule

// File: tb/tb_leitor_banco_registradores.sv
// Self-checking bench for leitor_banco_registradores: a word-queue model of the
// dump checked every cycle, directed scenarios with literal expectations, and a
// randomized phase with random backpressure, start noise and resets.
module tb_leitor_banco_registradores;

    localparam int LD = 32;
    localparam int BI = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    leitor_banco_registradores_if #(.LARGURA_DADOS(LD), .BITS_INDICE(BI)) bus ();

    leitor_banco_registradores #(.LARGURA_DADOS(LD), .BITS_INDICE(BI)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Register file: Rk = k*10, R0 configurable so the zero-R0 option is visible.
    logic [31:0] r0_val;
    always_comb begin
        bus.dados_leitura = (bus.reg_leitura == 5'd0) ? r0_val
                                                      : 32'(bus.reg_leitura) * 32'd10;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        int          cyc;
    } xfer_t;

    xfer_t log_q[$];
    xfer_t exp_q[$];
    int    conc_cnt = 0;
    int    conc_cyc = 0;

    // Model state: remaining words of the current dump and visible outputs.
    bit         m_init   = 0;
    bit         m_busy   = 0;
    bit         m_done   = 0;
    bit         m_valid  = 0;
    bit         m_rstd   = 0;
    logic [4:0] m_rl     = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [4:0] k, input logic [31:0] r0);
        if (k == 5'd0) begin
`ifdef ZERO_R0_EN
            return 32'd0;
`else
            return r0;
`endif
        end
        return 32'(k) * 32'd10;
    endfunction

    // Model update and transfer log, evaluated on the pre-edge values.
    initial begin : model
        logic [4:0] span;
        logic [4:0] k;
        xfer_t      w;
        forever begin
            @(posedge clk);
            if (rst !== 1'b1 && bus.saida_valid === 1'b1 && bus.saida_ready === 1'b1) begin
                w.idx  = bus.saida_indice;
                w.data = bus.saida_dados;
                w.cyc  = cyc;
                log_q.push_back(w);
            end
            if (rst === 1'b1) begin
                m_init  = 1;
                m_busy  = 0;
                m_done  = 0;
                m_valid = 0;
                m_rstd  = 1;
                m_rl    = '0;
                exp_q.delete();
            end else if (!m_init) begin
                m_init = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (!m_busy) begin
                if (bus.iniciar === 1'b1) begin
                    span = bus.reg_fim - bus.reg_inicio;
                    exp_q.delete();
                    for (int i = 0; i <= int'(span); i++) begin
                        k      = bus.reg_inicio + 5'(i);
                        w.idx  = k;
                        w.data = ref_word(k, r0_val);
                        w.cyc  = 0;
                        exp_q.push_back(w);
                    end
                    m_busy = 1;
                    m_rstd = 0;
                    m_rl   = bus.reg_inicio;
                end
            end else if (m_valid) begin
                if (bus.saida_ready === 1'b1) begin
                    void'(exp_q.pop_front());
                    m_valid = 0;
                    if (exp_q.size() == 0) begin
                        m_busy = 0;
                        m_done = 1;
                    end else begin
                        m_rl = exp_q[0].idx;
                    end
                end
            end else begin
                m_valid = 1;
            end
            cyc++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_init) begin
                check("valid", bus.saida_valid, m_valid);
                check("ocupado", bus.ocupado, m_busy || m_done);
                check("concluido", bus.concluido, m_done);
                check("reg_leitura", bus.reg_leitura, m_rl);
                if (m_valid && exp_q.size() > 0) begin
                    check("dados", bus.saida_dados, exp_q[0].data);
                    check("indice", bus.saida_indice, exp_q[0].idx);
                end
                if (m_rstd) begin
                    check("dados_rst", bus.saida_dados, 0);
                    check("indice_rst", bus.saida_indice, 0);
                end
            end
            if (bus.concluido === 1'b1) begin
                conc_cnt++;
                conc_cyc = cyc;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int e_start;

    task automatic start(input logic [4:0] ini, input logic [4:0] fim);
        bus.reg_inicio = ini;
        bus.reg_fim    = fim;
        bus.iniciar    = 1'b1;
        tick();
        e_start     = cyc - 1;
        bus.iniciar = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (bus.ocupado === 1'b1 && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
        end
    endtask

    int ord[4] = '{30, 31, 0, 1};

    initial begin : stim
        int n;
        rst              = 1'b1;
        bus.iniciar      = 1'b1;
        bus.reg_inicio   = '0;
        bus.reg_fim      = '0;
        bus.saida_ready  = 1'b0;
        r0_val           = 32'd0;

        // Reset with Iniciar held: everything idle and zero.
        tick();
        tick();
        check("rst_valid", bus.saida_valid, 0);
        check("rst_ocupado", bus.ocupado, 0);
        check("rst_dados", bus.saida_dados, 0);
        check("rst_indice", bus.saida_indice, 0);
        check("rst_rl", bus.reg_leitura, 0);
        check("rst_concluido", bus.concluido, 0);
        rst         = 1'b0;
        bus.iniciar = 1'b0;
        tick();

        // 2..4 with ready high: transfers on edges +2, +4, +6.
        log_q.delete();
        conc_cnt        = 0;
        bus.saida_ready = 1'b1;
        start(5'd2, 5'd4);
        wait_idle(50);
        check("d1_count", log_q.size(), 3);
        for (int i = 0; i < 3 && i < log_q.size(); i++) begin
            check("d1_idx", log_q[i].idx, 2 + i);
            check("d1_data", log_q[i].data, (2 + i) * 10);
            check("d1_cyc", log_q[i].cyc, e_start + 2 + 2 * i);
        end
        check("d1_conc_cnt", conc_cnt, 1);
        check("d1_conc_cyc", conc_cyc, e_start + 7);
        check("d1_idle", bus.ocupado, 0);

        // Backpressure on register 5.
        log_q.delete();
        bus.saida_ready = 1'b0;
        start(5'd5, 5'd5);
        n = 0;
        while (bus.saida_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("d2_valid_rise", n < 10, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("d2_hold_valid", bus.saida_valid, 1);
            check("d2_hold_dados", bus.saida_dados, 50);
            check("d2_hold_indice", bus.saida_indice, 5);
        end
        check("d2_no_xfer", log_q.size(), 0);
        bus.saida_ready = 1'b1;
        tick();
        bus.saida_ready = 1'b0;
        wait_idle(10);
        check("d2_count", log_q.size(), 1);

        // Wrap-around 30..1.
        log_q.delete();
        conc_cnt        = 0;
        bus.saida_ready = 1'b1;
        start(5'd30, 5'd1);
        wait_idle(50);
        check("d3_count", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check("d3_idx", log_q[i].idx, ord[i]);
        end
        check("d3_conc_cnt", conc_cnt, 1);

        // R0 returns 999 from the register file.
        log_q.delete();
        r0_val = 32'd999;
        start(5'd0, 5'd0);
        wait_idle(20);
        check("d4_count", log_q.size(), 1);
        if (log_q.size() > 0) begin
`ifdef ZERO_R0_EN
            check("d4_r0", log_q[0].data, 0);
`else
            check("d4_r0", log_q[0].data, 999);
`endif
        end

        // Start noise mid-dump, then reset while offering index 3 of 2..6.
        log_q.delete();
        conc_cnt = 0;
        r0_val   = 32'd0;
        start(5'd2, 5'd6);
        bus.iniciar    = 1'b1;
        bus.reg_inicio = 5'd9;
        bus.reg_fim    = 5'd9;
        tick();
        bus.iniciar = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.saida_valid === 1'b1 && bus.saida_indice === 5'd3) && n < 50);
        check("d5_reach3", n < 50, 1);
        rst             = 1'b1;
        bus.saida_ready = 1'b0;
        tick();
        rst = 1'b0;
        check("d5_valid", bus.saida_valid, 0);
        check("d5_ocupado", bus.ocupado, 0);
        for (int i = 0; i < 5; i++) tick();
        check("d5_conc", conc_cnt, 0);
        check("d5_count", log_q.size(), 1);
        if (log_q.size() > 0) check("d5_idx", log_q[0].idx, 2);

        // Randomized dumps with backpressure, start noise and rare resets.
        for (int d = 0; d < 20; d++) begin
            r0_val = ($urandom_range(0, 3) == 0) ? 32'd999 : 32'd0;
            start(5'($urandom), 5'($urandom));
            n = 0;
            while (n < 400) begin
                bus.saida_ready = 1'($urandom_range(0, 1));
                bus.iniciar     = ($urandom_range(0, 7) == 0);
                bus.reg_inicio  = 5'($urandom);
                bus.reg_fim     = 5'($urandom);
                rst             = ($urandom_range(0, 99) == 0);
                tick();
                n++;
                if (bus.ocupado !== 1'b1) break;
            end
            bus.iniciar     = 1'b0;
            rst             = 1'b0;
            bus.saida_ready = 1'b0;
            if (n >= 400) begin
                checks++;
                failures++;
                $display("FAIL rand_done: got busy after %0d cycles expected idle", n);
            end
            tick();
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
